// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// riscv_lsu : RV32I load/store unit; word-aligned memory access with byte
//             enables, ready-handshake wait states, load data extension.
//             Optional macro LSU_TIMEOUT_EN enables the BUSY watchdog.
// Revision  : 1.0
// ============================================================================
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic        req_c, stall_c;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // In IDLE the request is taken straight from the core; afterwards the
  // latched copy keeps every mem_* output frozen until completion.
  logic        in_idle;
  logic        eff_we;
  logic [1:0]  eff_off;
  logic [2:0]  eff_size;
  logic [29:0] eff_addr;
  logic [31:0] eff_wd;

  assign in_idle  = (state_q == IDLE);
  assign eff_we   = in_idle ? core_we_i          : we_q;
  assign eff_off  = in_idle ? core_addr_i[1:0]   : off_q;
  assign eff_size = in_idle ? core_size_i        : size_q;
  assign eff_addr = in_idle ? core_addr_i[31:2]  : addr_q;
  assign eff_wd   = in_idle ? core_wd_i          : wd_q;

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size[1:0])
      2'b00:   store_wd = {4{wd[7:0]}};
      2'b01:   store_wd = {2{wd[15:0]}};
      default: store_wd = wd;
    endcase
  endfunction

  // size[2] selects zero extension (LBU/LHU); 3, 6 and 7 fall into word.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] size,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size[1:0])
      2'b00:   load_ext = size[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = size[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          off_d   = core_addr_i[1:0];
          size_d  = core_size_i;
          we_d    = core_we_i;
          addr_d  = core_addr_i[31:2];
          wd_d    = core_wd_i;
          if (mem_ready_i) begin
            state_d = DONE;
            if (!core_we_i) rd_d = load_ext(mem_rd_i, core_size_i, core_addr_i[1:0]);
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (mem_ready_i) begin
          state_d = DONE;
          if (!we_q) rd_d = load_ext(mem_rd_i, size_q, off_q);
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) rd_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req_o    = rst_i & req_c;
  assign core_stall_o = rst_i & stall_c;
  assign mem_we_o     = mem_req_o & eff_we;
  assign mem_be_o     = eff_we ? store_be(eff_size, eff_off) : 4'b1111;
  assign mem_addr_o   = {eff_addr, 2'b00};
  assign mem_wd_o     = store_wd(eff_size, eff_wd);
  assign core_rd_o    = rd_q;

`ifdef LSU_TIMEOUT_EN
  assign err_o = err_q;
`else
  // Constant 0; the term keeps TIMEOUT_CYCLES referenced when no watchdog exists.
  assign err_o = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// tb_riscv_lsu : directed vector table, randomized transactions against a
// behavioural model, plus reset/wait-state/watchdog sequences.
module tb_riscv_lsu;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i),
    .err_o        (err_o)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: lane arithmetic straight from the access rules.
  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned sz   = int'(size) % 4;
    int unsigned lane = addr % 4;
    logic [31:0] v;
    if (sz == 0) begin
      v = (word >> (8 * lane)) & 32'hFF;
      if (size < 3'd4 && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 1) begin
      v = (word >> (16 * (lane / 2))) & 32'hFFFF;
      if (size < 3'd4 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [2:0] size, input logic [31:0] addr);
    int unsigned sz   = int'(size) % 4;
    int unsigned lane = addr % 4;
    if (!we || sz >= 2) return 4'hF;
    if (sz == 0) return 4'(1 << lane);
    return 4'(3 << (2 * (lane / 2)));
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] size, input logic [31:0] wd);
    int unsigned sz = int'(size) % 4;
    if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // One full transaction: request cycle, `waits` BUSY cycles, then DONE.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                         input int waits, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd);
    int          stalls = 0;
    logic [31:0] exp_addr = addr & 32'hFFFF_FFFC;
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = (waits == 0);
    mem_rd_i    = (waits == 0) ? rdata : $urandom;
    #1;
    check({tag, ".req"}, mem_req_o, 1);
    check({tag, ".be"}, mem_be_o, exp_be);
    check({tag, ".addr"}, mem_addr_o, exp_addr);
    check({tag, ".we"}, mem_we_o, we);
    if (we) check({tag, ".wd"}, mem_wd_o, exp_wd);
    if (core_stall_o) stalls++;
    for (int k = 1; k <= waits; k++) begin
      @(posedge clk_i); #1;
      mem_ready_i = (k == waits);
      mem_rd_i    = (k == waits) ? rdata : $urandom;
      #1;
      check($sformatf("%s.busy%0d.req", tag, k), mem_req_o, 1);
      check($sformatf("%s.busy%0d.hold", tag, k), {mem_be_o, 27'd0, mem_we_o},
            {exp_be, 27'd0, we});
      check($sformatf("%s.busy%0d.addr", tag, k), mem_addr_o, exp_addr);
      if (we) check($sformatf("%s.busy%0d.wd", tag, k), mem_wd_o, exp_wd);
      if (core_stall_o) stalls++;
    end
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    mem_rd_i    = $urandom;
    #1;
    check({tag, ".done_stall"}, core_stall_o, 0);
    check({tag, ".done_req"}, {mem_req_o, mem_we_o}, 0);
    check({tag, ".rd"}, core_rd_o, exp_rd);
    check({tag, ".err"}, err_o, 0);
    check({tag, ".stall_len"}, stalls, 1 + waits);
    model_rd = exp_rd;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk_i); #1;
    core_req_i  = 1'b0;
    mem_ready_i = 1'($urandom % 2);
    mem_rd_i    = $urandom;
    #1;
    check({tag, ".idle_req"}, {mem_req_o, core_stall_o}, 0);
    check({tag, ".idle_rd"}, core_rd_o, model_rd);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80112233, 0, 32'hFFFFFF80, 4'hF, 32'h0};
    vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80112233, 1, 32'h00000080, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0,        0, 32'h00000080, 4'hC, 32'hABCDABCD};
    vecs[4]  = '{1'b0, 3'd2, 32'h104, 32'h0,        32'h12345678, 3, 32'h12345678, 4'hF, 32'h0};
    vecs[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 0, 32'hFFFF8001, 4'hF, 32'h0};
    vecs[6]  = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h80017FFF, 2, 32'h00007FFF, 4'hF, 32'h0};
    vecs[7]  = '{1'b1, 3'd0, 32'h301, 32'h000000A5, 32'h0,        1, 32'h00007FFF, 4'h2, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 3'd2, 32'h403, 32'hCAFEF00D, 32'h0,        0, 32'h00007FFF, 4'hF, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 0, 32'h0000007F, 4'hF, 32'h0};
    vecs[10] = '{1'b0, 3'd3, 32'h007, 32'h0,        32'h11223344, 1, 32'h11223344, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 3'd1, 32'h101, 32'h0,        32'hABCD1234, 0, 32'h00001234, 4'hF, 32'h0};
    vecs[12] = '{1'b1, 3'd0, 32'h003, 32'h12345678, 32'h0,        0, 32'h00001234, 4'h8, 32'h78787878};
    vecs[13] = '{1'b0, 3'd5, 32'h0FE, 32'h0,        32'hFEDC0000, 0, 32'h0000FEDC, 4'hF, 32'h0};

    rst_i       = 1'b0;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b0;

    // Reset forces the request path low even with a pending core request.
    #2;
    check("rst.req_forced", {mem_req_o, core_stall_o}, 0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("rst.rd", core_rd_o, 0);
    check("rst.err", err_o, 0);
    rst_i      = 1'b1;
    core_req_i = 1'b0;

    for (int i = 0; i < 14; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd,
              vecs[i].rdata, vecs[i].waits, vecs[i].exp_rd, vecs[i].exp_be, vecs[i].exp_wd);
    idle_cycle("post_vec_a");
    idle_cycle("post_vec_b");

    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr, wd, rdata;
      int          waits;
      logic [31:0] exp_rd;
      we    = 1'($urandom % 2);
      size  = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wd    = $urandom;
      rdata = $urandom;
      waits = int'($urandom_range(0, TO - 1));
      exp_rd = we ? model_rd : ref_load(size, addr, rdata);
      run_txn($sformatf("rnd%0d", i), we, size, addr, wd, rdata, waits, exp_rd,
              ref_be(we, size, addr), ref_wd(size, wd));
      if ($urandom % 3 == 0) idle_cycle($sformatf("rnd%0d", i));
    end

    // Ready arriving on the TO-th BUSY cycle completes normally.
    run_txn("edge_wait", 1'b0, 3'd2, 32'h700, 32'h0, 32'h0BADF00D, TO, 32'h0BADF00D, 4'hF, 32'h0);
`ifndef LSU_TIMEOUT_EN
    run_txn("long_wait", 1'b0, 3'd4, 32'h702, 32'h0, 32'h00C30000, 12, 32'h000000C3, 4'hF, 32'h0);
`endif

    // Reset while BUSY abandons the access; a later stray ready is ignored.
    run_txn("pre_rst", 1'b0, 3'd2, 32'h500, 32'h0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 4'hF, 32'h0);
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h504;
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    check("busy_rst.forced", {mem_req_o, core_stall_o}, 0);
    @(posedge clk_i); #1;
    rst_i       = 1'b1;
    core_req_i  = 1'b0;
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'hFFFFFFFF;
    #1;
    check("busy_rst.idle", {mem_req_o, core_stall_o}, 0);
    check("busy_rst.rd", core_rd_o, 0);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    #1;
    check("busy_rst.stray_rd", core_rd_o, 0);
    check("busy_rst.stray_stall", core_stall_o, 0);
    model_rd = 32'h0;
    idle_cycle("post_rst");

`ifdef LSU_TIMEOUT_EN
    run_txn("pre_to", 1'b0, 3'd2, 32'h600, 32'h0, 32'h77777777, 0, 32'h77777777, 4'hF, 32'h0);
    begin
      int stalls = 0;
      @(posedge clk_i); #1;
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = 3'd2;
      core_addr_i = 32'h604;
      mem_ready_i = 1'b0;
      #1;
      if (core_stall_o) stalls++;
      for (int k = 1; k <= TO; k++) begin
        @(posedge clk_i); #1;
        #1;
        if (core_stall_o) stalls++;
      end
      check("to.stall_len", stalls, 1 + TO);
      @(posedge clk_i); #1;
      #1;
      check("to.done_stall", {mem_req_o, core_stall_o}, 0);
      check("to.err", err_o, 1);
      check("to.rd", core_rd_o, 0);
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      #1;
      check("to.err_pulse", err_o, 0);
      model_rd = 32'h0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
